// File: rtl/cpu_defines.sv
// Shared CPU definitions for the mul/div path: opcodes, sequencer states,
// HI/LO bus width and small opcode decode helpers.
package cpu_defines;

    localparam int HILO_W = 64;

    // mul/div opcodes as presented by EX
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // sequencer state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic md_is_div(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Issue/result handshake between the mul/div sequencer and the iterative unit.
interface muldiv_ctrl_if;
    import cpu_defines::*;

    logic              unit_start;
    logic              unit_signed;
    logic              unit_is_div;
    logic [31:0]       unit_a;
    logic [31:0]       unit_b;
    logic              unit_cancel;
    logic              unit_ready;
    logic [HILO_W-1:0] unit_result;

    // sequencer side
    modport master (
        output unit_start, unit_signed, unit_is_div, unit_a, unit_b, unit_cancel,
        input  unit_ready, unit_result
    );

    // mul_div unit side
    modport slave (
        input  unit_start, unit_signed, unit_is_div, unit_a, unit_b, unit_cancel,
        output unit_ready, unit_result
    );

endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared multi-cycle mul/div unit: accepts one request per
// instruction, stalls EX while the unit works, writes HI/LO exactly once and
// handles flush, divide-by-zero and the busy-cycle watchdog.
module muldiv_ctrl
    import cpu_defines::*;
#(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [1:0]        req_op,
    input  logic [31:0]       req_a,
    input  logic [31:0]       req_b,
    input  logic              flush,
    input  logic              hold,
    output logic              stallreq,
    muldiv_ctrl_if.master     unit,
    output logic              hilo_we,
    output logic [HILO_W-1:0] hilo_wdata,
    output logic              err
);

    // value the counter holds during the last permitted busy cycle
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    logic [1:0]        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              signed_q, signed_d;
    logic              is_div_q, is_div_d;
    logic [31:0]       a_q,      a_d;
    logic [31:0]       b_q,      b_d;
    logic [HILO_W-1:0] result_q, result_d;
    logic              err_q,    err_d;

    logic accept;
    logic timeout;

    assign accept  = (state_q == ST_IDLE) && req_valid && !flush;
    assign timeout = (state_q == ST_BUSY) && (cnt_q == CNT_LAST) && !unit.unit_ready;

    // next-state, operand latch, result capture and watchdog counting
    always_comb begin
        // NOTE: every *_d takes its current value first so no branch can leave it unassigned and infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        signed_d = signed_q;
        is_div_d = is_div_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    signed_d = md_is_signed(req_op);
                    is_div_d = md_is_div(req_op);
                    a_d      = req_a;
                    b_d      = req_b;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    if (md_is_div(req_op) && (req_b == 32'd0)) begin
                        // divide by zero never reaches the unit
                        result_d = {req_a, 32'hFFFF_FFFF};
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (unit.unit_ready) begin
                    result_d = unit.unit_result;
                    cnt_d    = '0;
                    state_d  = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                // EX advances when not held, so the request is consumed here
                if (flush || !hold) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: operand and result registers are reset too, so every output reads 0 out of reset.
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            signed_q <= 1'b0;
            is_div_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            signed_q <= signed_d;
            is_div_q <= is_div_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // stall in the accepting cycle and throughout BUSY unless flushed
    assign stallreq = accept || ((state_q == ST_BUSY) && !flush);

    // start pulses only while the counter is still at its first value
    assign unit.unit_start  = (state_q == ST_BUSY) && (cnt_q == '0);
    assign unit.unit_cancel = (state_q == ST_BUSY) && (flush || timeout);
    assign unit.unit_signed = signed_q;
    assign unit.unit_is_div = is_div_q;
    assign unit.unit_a      = a_q;
    assign unit.unit_b      = b_q;

    assign hilo_we    = (state_q == ST_DONE) && !hold && !flush;
    assign hilo_wdata = result_q;
    assign err        = err_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl; the bench plays the role of the mul_div unit.
module tb_muldiv_ctrl;
    import cpu_defines::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        flush = 1'b0;
    logic        hold = 1'b0;
    logic        stallreq;
    logic        hilo_we;
    logic [63:0] hilo_wdata;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          n_stall;
        int          n_start;
        int          n_cancel;
        int          n_we;
        int          we_at;
        int          cancel_at;
        logic [63:0] wdata;
        logic        sgn;
        logic        isdiv;
        logic [31:0] ua;
        logic [31:0] ub;
        logic        err_we;
        int          tail_we;
        int          tail_start;
        int          tail_stall;
    } run_t;

    muldiv_ctrl_if u_if ();

    muldiv_ctrl #(.MAX_CYCLES(40), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .flush      (flush),
        .hold       (hold),
        .stallreq   (stallreq),
        .unit       (u_if),
        .hilo_we    (hilo_we),
        .hilo_wdata (hilo_wdata),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within bound");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one request starting in IDLE; cycle 0 is the accepting cycle.
    // ready_at = 0 means the unit never answers.
    task automatic op_run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int ready_at, input int hold_lo, input int hold_hi,
                          input logic [63:0] res, output run_t r);
        bit done;
        done = 0;
        r = '{default: 0};
        r.we_at = -1;
        r.cancel_at = -1;
        for (int i = 0; i < 100 && !done; i++) begin
            req_valid = 1'b1;
            req_op = op;
            req_a = a;
            req_b = b;
            u_if.unit_ready = (ready_at > 0) && (i == ready_at);
            u_if.unit_result = res;
            hold = (i >= hold_lo) && (i <= hold_hi);
            #1;
            if (stallreq) r.n_stall++;
            if (u_if.unit_start) r.n_start++;
            if (u_if.unit_cancel) begin
                r.n_cancel++;
                if (r.cancel_at < 0) r.cancel_at = i;
            end
            if (i == 1) begin
                r.sgn = u_if.unit_signed;
                r.isdiv = u_if.unit_is_div;
                r.ua = u_if.unit_a;
                r.ub = u_if.unit_b;
            end
            if (hilo_we) begin
                r.n_we++;
                r.we_at = i;
                r.wdata = hilo_wdata;
                r.err_we = err;
                done = 1;
            end
            cyc();
        end
        req_valid = 1'b0;
        u_if.unit_ready = 1'b0;
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (hilo_we) r.tail_we++;
            if (u_if.unit_start) r.tail_start++;
            if (stallreq) r.tail_stall++;
            cyc();
        end
    endtask

    task automatic test_reset();
        u_if.unit_ready = 1'b0;
        u_if.unit_result = '0;
        rst = 1'b0;
        cyc();
        cyc();
        n_checks++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL reset_stallreq: got %b expected 0", stallreq); end
        n_checks++; if (hilo_we !== 1'b0) begin n_fail++; $display("FAIL reset_hilo_we: got %b expected 0", hilo_we); end
        n_checks++; if (hilo_wdata !== 64'd0) begin n_fail++; $display("FAIL reset_hilo_wdata: got %h expected 0", hilo_wdata); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (u_if.unit_start !== 1'b0 || u_if.unit_cancel !== 1'b0) begin n_fail++; $display("FAIL reset_unit_pulses: got start=%b cancel=%b expected 0/0", u_if.unit_start, u_if.unit_cancel); end
        n_checks++; if ({u_if.unit_signed, u_if.unit_is_div, u_if.unit_a, u_if.unit_b} !== 66'd0) begin n_fail++; $display("FAIL reset_unit_operands: got sgn=%b div=%b a=%h b=%h expected all 0", u_if.unit_signed, u_if.unit_is_div, u_if.unit_a, u_if.unit_b); end
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_div_basic();
        run_t r;
        op_run(MD_DIV, 32'd100, 32'd7, 33, 1, 0, {32'd2, 32'd14}, r);
        n_checks++; if (r.n_stall !== 34) begin n_fail++; $display("FAIL div_stall_cycles: got %0d expected 34", r.n_stall); end
        n_checks++; if (r.we_at !== 34) begin n_fail++; $display("FAIL div_we_cycle: got %0d expected 34", r.we_at); end
        n_checks++; if (r.wdata !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL div_wdata: got %h expected %h", r.wdata, {32'd2, 32'd14}); end
        n_checks++; if (r.n_start !== 1) begin n_fail++; $display("FAIL div_start_count: got %0d expected 1", r.n_start); end
        n_checks++; if (r.sgn !== 1'b1 || r.isdiv !== 1'b1) begin n_fail++; $display("FAIL div_flags: got sgn=%b div=%b expected 1/1", r.sgn, r.isdiv); end
        n_checks++; if (r.ua !== 32'd100 || r.ub !== 32'd7) begin n_fail++; $display("FAIL div_operands: got a=%0d b=%0d expected 100/7", r.ua, r.ub); end
        n_checks++; if (r.n_cancel !== 0) begin n_fail++; $display("FAIL div_cancel_count: got %0d expected 0", r.n_cancel); end
        n_checks++; if (r.tail_we !== 0 || r.tail_start !== 0) begin n_fail++; $display("FAIL div_single_write: got tail_we=%0d tail_start=%0d expected 0/0", r.tail_we, r.tail_start); end
    endtask

    task automatic test_multu_fast();
        run_t r;
        op_run(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1, 1, 0, 64'h1_FFFF_FFFE, r);
        n_checks++; if (r.we_at !== 2) begin n_fail++; $display("FAIL multu_we_cycle: got %0d expected 2", r.we_at); end
        n_checks++; if (r.wdata !== 64'h1_FFFF_FFFE) begin n_fail++; $display("FAIL multu_wdata: got %h expected 00000001fffffffe", r.wdata); end
        n_checks++; if (r.sgn !== 1'b0 || r.isdiv !== 1'b0) begin n_fail++; $display("FAIL multu_flags: got sgn=%b div=%b expected 0/0", r.sgn, r.isdiv); end
        n_checks++; if (r.n_stall !== 2 || r.n_start !== 1) begin n_fail++; $display("FAIL multu_stall_start: got stall=%0d start=%0d expected 2/1", r.n_stall, r.n_start); end
    endtask

    task automatic test_div_by_zero();
        run_t r;
        op_run(MD_DIVU, 32'd5, 32'd0, 0, 1, 0, 64'h0, r);
        n_checks++; if (r.we_at !== 1) begin n_fail++; $display("FAIL divz_we_cycle: got %0d expected 1", r.we_at); end
        n_checks++; if (r.wdata !== {32'd5, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL divz_wdata: got %h expected 00000005ffffffff", r.wdata); end
        n_checks++; if (r.n_start !== 0 || r.tail_start !== 0) begin n_fail++; $display("FAIL divz_no_start: got start=%0d tail_start=%0d expected 0/0", r.n_start, r.tail_start); end
        n_checks++; if (r.n_stall !== 1) begin n_fail++; $display("FAIL divz_stall_cycles: got %0d expected 1", r.n_stall); end
    endtask

    task automatic test_hold();
        run_t r;
        // DONE is reached on cycle 2; hold covers cycles 2..4
        op_run(MD_MULT, 32'hFFFF_FFFD, 32'd4, 1, 2, 4, 64'hFFFF_FFFF_FFFF_FFF4, r);
        n_checks++; if (r.we_at !== 5) begin n_fail++; $display("FAIL hold_we_cycle: got %0d expected 5", r.we_at); end
        n_checks++; if (r.n_we !== 1 || r.tail_we !== 0) begin n_fail++; $display("FAIL hold_we_count: got %0d+%0d expected 1+0", r.n_we, r.tail_we); end
        n_checks++; if (r.wdata !== 64'hFFFF_FFFF_FFFF_FFF4) begin n_fail++; $display("FAIL hold_wdata: got %h expected fffffffffffffff4", r.wdata); end
        n_checks++; if (r.n_start !== 1 || r.tail_start !== 0) begin n_fail++; $display("FAIL hold_no_reissue: got start=%0d tail_start=%0d expected 1/0", r.n_start, r.tail_start); end
        n_checks++; if (r.sgn !== 1'b1 || r.isdiv !== 1'b0) begin n_fail++; $display("FAIL hold_flags: got sgn=%b div=%b expected 1/0", r.sgn, r.isdiv); end
    endtask

    task automatic test_timeout();
        run_t r;
        run_t r2;
        op_run(MD_DIV, 32'd1, 32'd1, 0, 1, 0, 64'hAAAA_AAAA_AAAA_AAAA, r);
        n_checks++; if (r.cancel_at !== 40 || r.n_cancel !== 1) begin n_fail++; $display("FAIL timeout_cancel: got at=%0d count=%0d expected 40/1", r.cancel_at, r.n_cancel); end
        n_checks++; if (r.we_at !== 41) begin n_fail++; $display("FAIL timeout_we_cycle: got %0d expected 41", r.we_at); end
        n_checks++; if (r.wdata !== 64'd0) begin n_fail++; $display("FAIL timeout_wdata: got %h expected 0", r.wdata); end
        n_checks++; if (r.err_we !== 1'b1) begin n_fail++; $display("FAIL timeout_err_set: got %b expected 1", r.err_we); end
        n_checks++; if (r.n_stall !== 41) begin n_fail++; $display("FAIL timeout_stall_cycles: got %0d expected 41", r.n_stall); end
        #1;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_sticky: got %b expected 1", err); end
        op_run(MD_DIVU, 32'd9, 32'd0, 0, 1, 0, 64'h0, r2);
        n_checks++; if (r2.err_we !== 1'b0) begin n_fail++; $display("FAIL timeout_err_clear: got %b expected 0", r2.err_we); end
    endtask

    task automatic test_flush();
        // DIV in BUSY, flushed on cycle 10 together with a ready pulse
        req_valid = 1'b1; req_op = MD_DIV; req_a = 32'd50; req_b = 32'd5;
        u_if.unit_ready = 1'b0; flush = 1'b0; hold = 1'b0;
        #1;
        n_checks++; if (stallreq !== 1'b1) begin n_fail++; $display("FAIL flush_accept_stall: got %b expected 1", stallreq); end
        cyc();
        for (int i = 1; i < 10; i++) cyc();
        flush = 1'b1; u_if.unit_ready = 1'b1; u_if.unit_result = 64'hDEAD_BEEF;
        #1;
        n_checks++; if (u_if.unit_cancel !== 1'b1) begin n_fail++; $display("FAIL flush_busy_cancel: got %b expected 1", u_if.unit_cancel); end
        n_checks++; if (stallreq !== 1'b0 || hilo_we !== 1'b0) begin n_fail++; $display("FAIL flush_busy_outputs: got stall=%b we=%b expected 0/0", stallreq, hilo_we); end
        cyc();
        // next request accepted in the very next cycle
        flush = 1'b0; u_if.unit_ready = 1'b0;
        req_op = MD_MULTU; req_a = 32'd6; req_b = 32'd7;
        #1;
        n_checks++; if (stallreq !== 1'b1 || hilo_we !== 1'b0) begin n_fail++; $display("FAIL flush_reaccept: got stall=%b we=%b expected 1/0", stallreq, hilo_we); end
        cyc();
        u_if.unit_ready = 1'b1; u_if.unit_result = 64'd42;
        #1;
        n_checks++; if (u_if.unit_start !== 1'b1 || u_if.unit_a !== 32'd6 || u_if.unit_signed !== 1'b0) begin n_fail++; $display("FAIL flush_reissue: got start=%b a=%0d sgn=%b expected 1/6/0", u_if.unit_start, u_if.unit_a, u_if.unit_signed); end
        cyc();
        u_if.unit_ready = 1'b0;
        #1;
        n_checks++; if (hilo_we !== 1'b1 || hilo_wdata !== 64'd42) begin n_fail++; $display("FAIL flush_after_write: got we=%b data=%h expected 1/2a", hilo_we, hilo_wdata); end
        cyc();
        req_valid = 1'b0;
        // flush while in DONE drops the write
        req_valid = 1'b1; req_op = MD_DIVU; req_a = 32'd8; req_b = 32'd0;
        cyc();
        flush = 1'b1;
        #1;
        n_checks++; if (hilo_we !== 1'b0 || stallreq !== 1'b0) begin n_fail++; $display("FAIL flush_done: got we=%b stall=%b expected 0/0", hilo_we, stallreq); end
        cyc();
        flush = 1'b0; req_valid = 1'b0;
        #1;
        n_checks++; if (hilo_we !== 1'b0) begin n_fail++; $display("FAIL flush_done_after: got we=%b expected 0", hilo_we); end
        cyc();
        // flush in IDLE: request ignored
        req_valid = 1'b1; req_op = MD_MULT; flush = 1'b1;
        #1;
        n_checks++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall: got %b expected 0", stallreq); end
        cyc();
        req_valid = 1'b0; flush = 1'b0;
        #1;
        n_checks++; if (u_if.unit_start !== 1'b0 || stallreq !== 1'b0) begin n_fail++; $display("FAIL flush_idle_ignored: got start=%b stall=%b expected 0/0", u_if.unit_start, stallreq); end
        cyc();
    endtask

    task automatic test_ready_outside();
        int n_we;
        n_we = 0;
        u_if.unit_ready = 1'b1; u_if.unit_result = 64'd77;
        cyc();
        u_if.unit_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (hilo_we) n_we++;
            cyc();
        end
        n_checks++; if (n_we !== 0) begin n_fail++; $display("FAIL ready_idle_ignored: got %0d writes expected 0", n_we); end
    endtask

    task automatic test_reset_mid();
        int n_we;
        n_we = 0;
        req_valid = 1'b1; req_op = MD_MULT; req_a = 32'd3; req_b = 32'd3;
        cyc();
        cyc();
        cyc();
        // asynchronous reset away from any clock edge
        #2;
        rst = 1'b0; req_valid = 1'b0;
        #1;
        n_checks++; if (stallreq !== 1'b0 || u_if.unit_start !== 1'b0 || u_if.unit_a !== 32'd0) begin n_fail++; $display("FAIL reset_mid_outputs: got stall=%b start=%b a=%0d expected 0/0/0", stallreq, u_if.unit_start, u_if.unit_a); end
        cyc();
        rst = 1'b1;
        u_if.unit_ready = 1'b1; u_if.unit_result = 64'd9;
        cyc();
        u_if.unit_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (hilo_we) n_we++;
            cyc();
        end
        n_checks++; if (n_we !== 0) begin n_fail++; $display("FAIL reset_mid_no_write: got %0d writes expected 0", n_we); end
    endtask

    initial begin
        test_reset();
        test_div_basic();
        test_multu_fast();
        test_div_by_zero();
        test_hold();
        test_timeout();
        test_flush();
        test_ready_outside();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
